// File: rtl/vga_dither_out_if.sv
`default_nettype none
// ============================================================================
//  Module      : vga_dither_out_if
//  Description : Bundle between the VGA front end (timing + noise generator)
//                and the dither/output stage.
//                master : drives timing, coordinates, noise and palette
//                         request; observes the PMOD byte and frame counter.
//                slave  : the output stage (consumes inputs, drives outputs).
//  Signals     : hsync_in, vsync_in, display_on_in  timing flags (active high)
//                hpos, vpos [9:0]                   pixel coordinates
//                noise [7:0]                        intensity sample (lags
//                                                   coordinates by PIPE_LAT)
//                palette_sel [1:0]                  requested palette
//                uo_out [7:0]                       TinyVGA PMOD byte
//                frame_cnt [7:0]                    frame counter
//  Revision    : 1.0  initial release
// ============================================================================
interface vga_dither_out_if;

    logic       hsync_in;
    logic       vsync_in;
    logic       display_on_in;
    logic [9:0] hpos;
    logic [9:0] vpos;
    logic [7:0] noise;
    logic [1:0] palette_sel;
    logic [7:0] uo_out;
    logic [7:0] frame_cnt;

    modport master (
        output hsync_in,
        output vsync_in,
        output display_on_in,
        output hpos,
        output vpos,
        output noise,
        output palette_sel,
        input  uo_out,
        input  frame_cnt
    );

    modport slave (
        input  hsync_in,
        input  vsync_in,
        input  display_on_in,
        input  hpos,
        input  vpos,
        input  noise,
        input  palette_sel,
        output uo_out,
        output frame_cnt
    );

endinterface

`default_nettype wire

// File: rtl/vga_dither_out.sv
`default_nettype none
// ============================================================================
//  Module      : vga_dither_out
//  Description : VGA output stage. Delays the timing flags and the low
//                coordinate bits so they line up with the late-arriving
//                noise sample, maps the sample through one of four palettes,
//                applies a 4x4 ordered (Bayer) dither down to 2 bits per
//                channel (optionally rotating the pattern each frame) and
//                registers the TinyVGA PMOD byte.
//  Parameters  : PIPE_LAT  cycles by which noise lags hpos/vpos/sync (1..4)
//                TEMPORAL  1 = Bayer column offset follows frame_cnt[1:0]
//  Ports       : clk    pixel clock
//                rst_n  synchronous active-low reset
//                bus    vga_dither_out_if.slave
//                         in : hsync_in, vsync_in, display_on_in, hpos, vpos,
//                              noise, palette_sel
//                         out: uo_out = {hs, B0, G0, R0, vs, B1, G1, R1},
//                              frame_cnt
//  Latency     : hsync_in/hpos -> uo_out = PIPE_LAT + 1 cycles,
//                noise         -> uo_out = 1 cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module vga_dither_out #(
    parameter int PIPE_LAT = 2,
    parameter bit TEMPORAL = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    vga_dither_out_if.slave  bus
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    // One delay-line tap: {hsync, vsync, display_on, hpos[1:0], vpos[1:0]}
    localparam int TAP_W = 7;
    localparam int DLY_W = PIPE_LAT * TAP_W;

    localparam logic [1:0] PAL_GREY = 2'd0;
    localparam logic [1:0] PAL_WARM = 2'd1;
    localparam logic [1:0] PAL_COOL = 2'd2;
    localparam logic [1:0] PAL_RAW  = 2'd3;

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    // 4x4 Bayer threshold, indexed [row][column].
    function automatic logic [3:0] bayer_thresh(input logic [1:0] by,
                                                input logic [1:0] bx);
        logic [3:0] t;
        t = 4'd0;
        case ({by, bx})
            4'h0: t = 4'd0;
            4'h1: t = 4'd8;
            4'h2: t = 4'd2;
            4'h3: t = 4'd10;
            4'h4: t = 4'd12;
            4'h5: t = 4'd4;
            4'h6: t = 4'd14;
            4'h7: t = 4'd6;
            4'h8: t = 4'd3;
            4'h9: t = 4'd11;
            4'hA: t = 4'd1;
            4'hB: t = 4'd9;
            4'hC: t = 4'd15;
            4'hD: t = 4'd7;
            4'hE: t = 4'd13;
            4'hF: t = 4'd5;
            default: t = 4'd0;
        endcase
        return t;
    endfunction

    // level = (c*3 + t*16 + 8) >> 8. The sum peaks at 765+240+8 = 1013,
    // so 10 bits hold it and the top two bits are directly the 0..3 level.
    function automatic logic [1:0] quantise(input logic [7:0] c,
                                            input logic [3:0] t);
        logic [9:0] acc;
        acc = ({2'b00, c} * 10'd3) + {2'b00, t, 4'b0000} + 10'd8;
        return 2'(acc >> 8);
    endfunction

    // ------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------
    logic [TAP_W-1:0] tap_in;
    logic [TAP_W-1:0] tap_out;
    logic [DLY_W-1:0] dly_q;
    logic [DLY_W-1:0] dly_d;

    logic             hsync_dly;
    logic             vsync_dly;
    logic             disp_dly;
    logic [1:0]       hpos_dly;
    logic [1:0]       vpos_dly;

    logic             vsync_prev_q;
    logic             frame_evt;
    logic [7:0]       frame_cnt_q;
    logic [7:0]       frame_cnt_d;
    logic [1:0]       pal_q;
    logic [1:0]       pal_d;

    logic [1:0]       bx_off;
    logic [1:0]       bx;
    logic [3:0]       thresh;

    logic [7:0]       c_r;
    logic [7:0]       c_g;
    logic [7:0]       c_b;
    logic [1:0]       lvl_r;
    logic [1:0]       lvl_g;
    logic [1:0]       lvl_b;

    logic [7:0]       uo_q;
    logic [7:0]       uo_d;

    // Only the two low coordinate bits address the Bayer matrix.
    logic             unused_bits;
    assign unused_bits = ^{bus.hpos[9:2], bus.vpos[9:2]};

    // ------------------------------------------------------------------
    // Delay line: aligns timing/coordinates with the noise sample.
    // Newest tap sits in the low bits, oldest in the high bits.
    // ------------------------------------------------------------------
    assign tap_in = {bus.hsync_in, bus.vsync_in, bus.display_on_in,
                     bus.hpos[1:0], bus.vpos[1:0]};

    generate
        if (PIPE_LAT == 1) begin : g_dly_single
            always_comb dly_d = tap_in;
        end else begin : g_dly_multi
            always_comb dly_d = {dly_q[DLY_W-TAP_W-1:0], tap_in};
        end
    endgenerate

    assign tap_out   = dly_q[DLY_W-1 -: TAP_W];
    assign hsync_dly = tap_out[6];
    assign vsync_dly = tap_out[5];
    assign disp_dly  = tap_out[4];
    assign hpos_dly  = tap_out[3:2];
    assign vpos_dly  = tap_out[1:0];

    // ------------------------------------------------------------------
    // Frame boundary: rising edge of the undelayed vsync. A palette
    // request presented in the same cycle as the edge is taken.
    // ------------------------------------------------------------------
    assign frame_evt = bus.vsync_in & ~vsync_prev_q;

    always_comb begin
        frame_cnt_d = frame_cnt_q;
        pal_d       = pal_q;
        if (frame_evt) begin
            frame_cnt_d = frame_cnt_q + 8'd1;
            pal_d       = bus.palette_sel;
        end
    end

    // ------------------------------------------------------------------
    // Bayer coordinates
    // ------------------------------------------------------------------
    generate
        if (TEMPORAL) begin : g_temporal
            assign bx_off = frame_cnt_q[1:0];
        end else begin : g_static
            assign bx_off = 2'd0;
        end
    endgenerate

    assign bx     = hpos_dly + bx_off;   // wraps mod 4
    assign thresh = bayer_thresh(vpos_dly, bx);

    // ------------------------------------------------------------------
    // Palette, quantise, blank
    // ------------------------------------------------------------------
    always_comb begin
        c_r = bus.noise;
        c_g = bus.noise;
        c_b = bus.noise;
        case (pal_q)
            PAL_WARM: begin
                c_g = {1'b0, bus.noise[7:1]};
                c_b = 8'd0;
            end
            PAL_COOL: begin
                c_r = 8'd0;
                c_g = {1'b0, bus.noise[7:1]};
            end
            default: ;
        endcase

        lvl_r = quantise(c_r, thresh);
        lvl_g = quantise(c_g, thresh);
        lvl_b = quantise(c_b, thresh);

        // Raw palette bypasses the dither and scatters the sample bits.
        if (pal_q == PAL_RAW) begin
            lvl_r = {bus.noise[7], bus.noise[2]};
            lvl_g = {bus.noise[6], bus.noise[3]};
            lvl_b = {bus.noise[5], bus.noise[4]};
        end

        if (!disp_dly) begin
            lvl_r = 2'd0;
            lvl_g = 2'd0;
            lvl_b = 2'd0;
        end
    end

    // TinyVGA PMOD bit order: low colour bits on the upper nibble.
    assign uo_d = {hsync_dly, lvl_b[0], lvl_g[0], lvl_r[0],
                   vsync_dly, lvl_b[1], lvl_g[1], lvl_r[1]};

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dly_q        <= '0;
            vsync_prev_q <= 1'b0;
            frame_cnt_q  <= 8'd0;
            pal_q        <= PAL_GREY;
            uo_q         <= 8'h00;
        end else begin
            dly_q        <= dly_d;
            vsync_prev_q <= bus.vsync_in;
            frame_cnt_q  <= frame_cnt_d;
            pal_q        <= pal_d;
            uo_q         <= uo_d;
        end
    end

    assign bus.uo_out    = uo_q;
    assign bus.frame_cnt = frame_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_vga_dither_out.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vga_dither_out
//  Description : Self-checking bench for vga_dither_out. Two instances, one
//                static and one temporal Bayer pattern, see identical
//                stimulus. Each driven pixel's expected PMOD byte is pushed
//                to a per-instance queue and popped when the DUT emits it.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_vga_dither_out;

    localparam int PIPE_LAT = 2;
    localparam int BAYER [16] = '{ 0,  8,  2, 10,
                                  12,  4, 14,  6,
                                   3, 11,  1,  9,
                                  15,  7, 13,  5};

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    vga_dither_out_if bus_s ();
    vga_dither_out_if bus_t ();

    vga_dither_out #(.PIPE_LAT(PIPE_LAT), .TEMPORAL(1'b0)) dut_s (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_s)
    );

    vga_dither_out #(.PIPE_LAT(PIPE_LAT), .TEMPORAL(1'b1)) dut_t (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_t)
    );

    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] exp_s_q [$];
    logic [7:0] exp_t_q [$];
    logic [7:0] noise_q [$];
    int         frame_m   = 0;
    logic [1:0] pal_m     = 2'd0;
    logic       vs_prev_m = 1'b0;
    logic [1:0] psel      = 2'd0;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %02h expected %02h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int lvl(input int c, input int t);
        return (c * 3 + t * 16 + 8) / 256;
    endfunction

    function automatic logic [7:0] model_px(input logic hs, input logic vs, input logic don,
                                            input logic [9:0] hp, input logic [9:0] vp,
                                            input logic [7:0] n, input logic [1:0] pal,
                                            input int frame, input bit temporal);
        int cr, cg, cb, t, bx;
        logic [1:0] r, g, b;
        cr = int'(n);
        cg = int'(n);
        cb = int'(n);
        if (!don) begin
            r = 2'd0; g = 2'd0; b = 2'd0;
        end else if (pal == 2'd3) begin
            r = {n[7], n[2]};
            g = {n[6], n[3]};
            b = {n[5], n[4]};
        end else begin
            if (pal == 2'd1) begin cg = int'(n) / 2; cb = 0; end
            if (pal == 2'd2) begin cr = 0; cg = int'(n) / 2; end
            bx = (int'(hp) + (temporal ? frame : 0)) % 4;
            t  = BAYER[(int'(vp) % 4) * 4 + bx];
            r  = 2'(lvl(cr, t));
            g  = 2'(lvl(cg, t));
            b  = 2'(lvl(cb, t));
        end
        return {hs, b[0], g[0], r[0], vs, b[1], g[1], r[1]};
    endfunction

    task automatic set_inputs(input logic hs, input logic vs, input logic don,
                              input logic [9:0] hp, input logic [9:0] vp,
                              input logic [7:0] n, input logic [1:0] p);
        bus_s.hsync_in = hs;  bus_t.hsync_in = hs;
        bus_s.vsync_in = vs;  bus_t.vsync_in = vs;
        bus_s.display_on_in = don; bus_t.display_on_in = don;
        bus_s.hpos = hp;      bus_t.hpos = hp;
        bus_s.vpos = vp;      bus_t.vpos = vp;
        bus_s.noise = n;      bus_t.noise = n;
        bus_s.palette_sel = p; bus_t.palette_sel = p;
    endtask

    task automatic set_random();
        set_inputs(1'($urandom), 1'($urandom), 1'($urandom), 10'($urandom),
                   10'($urandom), 8'($urandom), 2'($urandom));
    endtask

    // Observe the outputs produced by the previous edge.
    task automatic sample();
        logic [7:0] es, et;
        @(posedge clk);
        #1;
        es = (exp_s_q.size() > 0) ? exp_s_q.pop_front() : 8'h00;
        et = (exp_t_q.size() > 0) ? exp_t_q.pop_front() : 8'h00;
        chk("uo_static",   bus_s.uo_out,    es);
        chk("uo_temporal", bus_t.uo_out,    et);
        chk("fc_static",   bus_s.frame_cnt, 8'(frame_m));
        chk("fc_temporal", bus_t.frame_cnt, 8'(frame_m));
    endtask

    // Drive one pixel: timing/coords now, its noise PIPE_LAT cycles later.
    task automatic drive_px(input logic hs, input logic vs, input logic don,
                            input logic [9:0] hp, input logic [9:0] vp, input logic [7:0] n);
        logic [7:0] nd;
        if (vs && !vs_prev_m) begin
            frame_m = (frame_m + 1) % 256;
            pal_m   = psel;
        end
        vs_prev_m = vs;
        noise_q.push_back(n);
        nd = noise_q.pop_front();
        set_inputs(hs, vs, don, hp, vp, nd, psel);
        exp_s_q.push_back(model_px(hs, vs, don, hp, vp, n, pal_m, frame_m, 1'b0));
        exp_t_q.push_back(model_px(hs, vs, don, hp, vp, n, pal_m, frame_m, 1'b1));
    endtask

    task automatic tick(input logic hs, input logic vs, input logic don,
                        input logic [9:0] hp, input logic [9:0] vp, input logic [7:0] n);
        sample();
        drive_px(hs, vs, don, hp, vp, n);
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) tick(1'b0, 1'b0, 1'b0, 10'd0, 10'd0, 8'($urandom));
    endtask

    task automatic do_reset(input int cycles);
        rst_n = 1'b0;
        set_random();
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            chk("rst_uo_s", bus_s.uo_out,    8'h00);
            chk("rst_uo_t", bus_t.uo_out,    8'h00);
            chk("rst_fc_s", bus_s.frame_cnt, 8'h00);
            chk("rst_fc_t", bus_t.frame_cnt, 8'h00);
            set_random();
        end
        rst_n = 1'b1;
        exp_s_q.delete();
        exp_t_q.delete();
        noise_q.delete();
        frame_m   = 0;
        pal_m     = 2'd0;
        vs_prev_m = 1'b0;
        for (int i = 0; i < PIPE_LAT; i++) begin
            exp_s_q.push_back(8'h00);
            exp_t_q.push_back(8'h00);
            noise_q.push_back(8'($urandom));
        end
        drive_px(1'b0, 1'b0, 1'b0, 10'd0, 10'd0, 8'($urandom));
    endtask

    // Blanked lead-in keeps displayed pixels clear of the frame update.
    task automatic vsync_pulse(input logic [1:0] p);
        idle(PIPE_LAT);
        psel = p;
        tick(1'b0, 1'b1, 1'b0, 10'd0, 10'd0, 8'($urandom));
        tick(1'b0, 1'b0, 1'b0, 10'd0, 10'd0, 8'($urandom));
    endtask

    task automatic random_pixels(input int count);
        for (int i = 0; i < count; i++)
            tick(1'($urandom), 1'b0, 1'b1, 10'($urandom_range(0, 639)),
                 10'($urandom_range(0, 479)), 8'($urandom));
    endtask

    initial begin
        set_inputs(1'b0, 1'b0, 1'b0, 10'd0, 10'd0, 8'd0, 2'd0);

        // Reset with random inputs
        do_reset(10);
        idle(3);

        // Grey dither row, frame 0
        psel = 2'd0;
        for (int h = 0; h < 4; h++) tick(1'b0, 1'b0, 1'b1, 10'(h), 10'd0, 8'h80);
        idle(PIPE_LAT + 1);

        // Extremes at all Bayer positions, plus blanked full-scale
        for (int v = 0; v < 4; v++)
            for (int h = 0; h < 4; h++) begin
                tick(1'b0, 1'b0, 1'b1, 10'(h), 10'(v), 8'h00);
                tick(1'b0, 1'b0, 1'b1, 10'(h), 10'(v), 8'hFF);
                tick(1'b0, 1'b0, 1'b0, 10'(h), 10'(v), 8'hFF);
            end
        idle(PIPE_LAT + 1);

        // Sync latency: isolated hsync then vsync pulses
        tick(1'b1, 1'b0, 1'b0, 10'd0, 10'd0, 8'hFF);
        idle(5);
        tick(1'b0, 1'b1, 1'b0, 10'd0, 10'd0, 8'hFF);
        idle(5);

        // Palette switch only takes effect at the next vsync rise
        vsync_pulse(2'd0);
        for (int h = 0; h < 4; h++) tick(1'b0, 1'b0, 1'b1, 10'(h), 10'd1, 8'hA5);
        psel = 2'd3;
        for (int h = 0; h < 4; h++) tick(1'b0, 1'b0, 1'b1, 10'(h), 10'd1, 8'hA5);
        vsync_pulse(2'd3);
        for (int h = 0; h < 4; h++) tick(1'b0, 1'b0, 1'b1, 10'(h), 10'd2, 8'hA5);
        random_pixels(16);
        vsync_pulse(2'd1);
        random_pixels(24);
        vsync_pulse(2'd2);
        random_pixels(24);
        vsync_pulse(2'd0);
        random_pixels(24);

        // Reset mid-frame with display data in flight
        random_pixels(3);
        do_reset(3);
        idle(PIPE_LAT + 1);

        // Temporal rotation and frame counter wrap
        tick(1'b0, 1'b0, 1'b1, 10'd0, 10'd0, 8'h80);
        vsync_pulse(2'd0);
        tick(1'b0, 1'b0, 1'b1, 10'd0, 10'd0, 8'h80);
        for (int f = 0; f < 256; f++) begin
            vsync_pulse(2'($urandom_range(0, 2)));
            tick(1'b0, 1'b0, 1'b1, 10'($urandom_range(0, 3)), 10'($urandom_range(0, 3)), 8'h80);
        end
        random_pixels(16);
        idle(PIPE_LAT + 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/vga_dither_out.md
Name: vga_dither_out

Overview:
- Output stage downstream of the VGA timing generator and the noise/pattern generator.
- Consumes timing signals, pixel coordinates and an 8-bit intensity sample, and aligns timing to the sample latency.
- Applies a palette and 4x4 ordered (Bayer) dither, optionally rotated per frame, producing 2-bit R/G/B.
- Drives the registered TinyVGA PMOD byte.

Parameters:
PIPE_LAT, 2, cycles by which noise lags hpos/vpos/sync inputs (1..4)
TEMPORAL, 1, 1 = Bayer column offset rotates with frame_cnt; 0 = static pattern

Ports:
clk  input  1  pixel clock
rst_n  input  1  synchronous active-low reset
hsync_in  input  1  horizontal sync, active high, aligned with hpos
vsync_in  input  1  vertical sync, active high, aligned with vpos
display_on_in  input  1  visible-area flag, aligned with hpos
hpos  input  10  pixel column
vpos  input  10  pixel row
noise  input  8  intensity sample, valid PIPE_LAT cycles after its hpos/vpos
palette_sel  input  2  requested palette; applied at frame boundary
uo_out  output  8  {hsync, B[0], G[0], R[0], vsync, B[1], G[1], R[1]}
frame_cnt  output  8  frame counter

Behaviour:
- Reset is sampled at clk: rst_n=0 clears the following to 0:
  - delay line (hsync, vsync, display_on, hpos[1:0], vpos[1:0])
  - uo_out = 8'h00
  - frame_cnt = 0
  - active palette = 0
  - previous-vsync register
- Reset mid-frame discards in-flight data; outputs stay 0 until real data propagates.
- Delay line:
  - PIPE_LAT-stage shift register carries hsync_in, vsync_in, display_on_in, hpos[1:0] and vpos[1:0].
  - Delayed values (suffix _d) are aligned with noise.
- Frame boundary:
  - Event fires on the rising edge of vsync_in (registered previous value 0, current 1).
  - On the event, frame_cnt increments mod 256 (255 -> 0) and palette_sel is captured into the active palette.
  - A palette_sel change in the same cycle as the event is captured.
- Palette (n = noise, 8-bit channels c_r/c_g/c_b):
  - 0 grey: c_r = c_g = c_b = n
  - 1 warm: c_r = n, c_g = n>>1, c_b = 0
  - 2 cool: c_r = 0, c_g = n>>1, c_b = n
  - 3 raw: no dither; R = {n[7], n[2]}, G = {n[6], n[3]}, B = {n[5], n[4]}
- Bayer coordinates:
  - bx = (hpos_d[1:0] + (TEMPORAL ? frame_cnt[1:0] : 0)) mod 4
  - by = vpos_d[1:0]
- Bayer matrix t[by][bx], rows:
  - 0 8 2 10
  - 12 4 14 6
  - 3 11 1 9
  - 15 7 13 5
- Quantise per channel: level = (c*3 + t*16 + 8) >> 8, computed at 10-bit width.
  - Maximum is 1013, so level is always 0..3 and no clamp is needed.
  - c = 0 gives 0; c = 255 gives 3.
- Blanking: display_on_d = 0 forces R = G = B = 0 in every palette.
- Output register: one registered stage; uo_out packs hsync_d, vsync_d and the levels.
- Total latency from hsync_in/hpos to uo_out is PIPE_LAT + 1 cycles; the noise sample appears 1 cycle after arrival.
- No combinational path from any input to uo_out.

Test Plan:
1. Reset: rst_n=0 for 10 cycles with random inputs -> uo_out = 8'h00 and frame_cnt = 0 every cycle.
2. Sync latency: PIPE_LAT=2, display_on_in=0, one-cycle hsync_in pulse at cycle N -> uo_out = 8'h80 only at N+3; all other cycles 8'h00. Repeat with vsync_in -> 8'h08 at N+3.
3. Grey dither: palette 0, TEMPORAL=0, display on, noise=8'h80, vpos=0, hpos=0..3 -> uo_out = 70, 07, 70, 07 (levels 1, 2, 1, 2).
4. Extremes: noise=8'h00 -> 8'h00 at all 16 Bayer positions; noise=8'hFF -> 8'h77 at all 16 positions. Same with display_on_in=0 and noise=8'hFF -> 8'h00.
5. Palette switch: set palette_sel=3 mid-frame -> output unchanged until the next vsync_in rise. After the rise, noise=8'hA5 -> RGB bits 8'h15 (R=3, G=0, B=2).
6. Temporal/wrap:
   - TEMPORAL=1, noise=8'h80, hpos=0, vpos=0 -> level 1 at frame_cnt=0, level 2 at frame_cnt=1.
   - Drive 256 vsync rises -> frame_cnt returns to 0.
